clock_field_sequencer: RTL

- Control stage directly upstream of the ALU control-signal register.
- On each 1 Hz tick, walks the seconds -> minutes -> hours carry chain: raises one bit of pla per field and drives the matching 2-bit op code on s0/s1/s2.
- Waits for the ALU's wrap flag before advancing to the next field.
- Also issues a global clear and single-field set-mode increments.

---
 rtl/clock_field_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_field_sequencer.sv
// Clock field sequencer: walks the sec -> min -> hour carry chain on each 1 Hz tick and drives ALU field selects and op codes.
// Latency: op outputs one clk after tick/clr_req/set_inc; each field takes 1 op cycle + ALU_LATENCY wait cycles.
// Backpressure: one tick is queued while busy; a further tick is dropped and flagged on tick_overrun; set_inc while busy is ignored.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   tick           one-cycle 1 Hz time-base pulse
//   clr_req        one-cycle pulse, clear all fields (aborts any chain in flight)
//   set_inc        one-cycle pulse, increment set_field without carry (0 sec, 1 min, 2 hour, 3 ignored)
//   wrap_in        ALU flag: the field just operated on wrapped to 0
//   pla            one-hot field select (bit0 sec, bit1 min, bit2 hour); 111 only for clear
//   s0/s1/s2       op codes for sec/min/hour: 00 HOLD, 01 INC, 10 CLR
//   busy           high whenever the FSM is not IDLE
//   tick_overrun   sticky: a tick was lost; cleared by reset or clr_req
//   day_tick       (only with DAY_TICK_OUT_EN) one-cycle pulse when hours wrap
//
// Build option: define DAY_TICK_OUT_EN to add the day_tick output.
// ALU_LATENCY: cycles from the op cycle to a valid wrap_in sample, legal 1..7.

module clock_field_sequencer #(
    parameter int ALU_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       clr_req,
    input  logic       set_inc,
    input  logic [1:0] set_field,
    input  logic       wrap_in,
    output logic [2:0] pla,
    output logic [1:0] s0,
    output logic [1:0] s1,
    output logic [1:0] s2,
    output logic       busy,
    output logic       tick_overrun
`ifdef DAY_TICK_OUT_EN
    ,
    output logic       day_tick
`endif
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    // The wait state is entered with LAT-1 and samples wrap_in when the
    // counter reads 0, so the sample lands exactly ALU_LATENCY cycles after
    // the op cycle.
    localparam logic [2:0] WAIT_LOAD = 3'(ALU_LATENCY - 1);

    typedef enum logic [3:0] {
        IDLE,
        SEC_OP,
        SEC_WAIT,
        MIN_OP,
        MIN_WAIT,
        HOUR_OP,
        HOUR_WAIT,
        CLR_OP,
        SET_OP
    } state_t;

    state_t     state;
    logic       pending;
    logic [2:0] wait_cnt;

    // All outputs are registered and decoded from the state being entered,
    // so pla/s*/busy line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pla          <= 3'b000;
            s0           <= OP_HOLD;
            s1           <= OP_HOLD;
            s2           <= OP_HOLD;
            busy         <= 1'b0;
            tick_overrun <= 1'b0;
            pending      <= 1'b0;
            wait_cnt     <= 3'd0;
`ifdef DAY_TICK_OUT_EN
            day_tick     <= 1'b0;
`endif
        end else begin
            // Outside an op cycle every field holds.
            pla  <= 3'b000;
            s0   <= OP_HOLD;
            s1   <= OP_HOLD;
            s2   <= OP_HOLD;
            busy <= 1'b0;
`ifdef DAY_TICK_OUT_EN
            day_tick <= 1'b0;
`endif
            if (clr_req) begin
                // Clear wins over everything: any carry in flight and any
                // queued or simultaneous tick are discarded, since the clear
                // defines the new time.
                state        <= CLR_OP;
                pla          <= 3'b111;
                s0           <= OP_CLR;
                s1           <= OP_CLR;
                s2           <= OP_CLR;
                busy         <= 1'b1;
                pending      <= 1'b0;
                tick_overrun <= 1'b0;
                wait_cnt     <= 3'd0;
            end else begin
                // One-deep tick queue. A tick that cannot be served this edge
                // is parked in pending; with pending already full it is lost.
                if (tick && (state != IDLE || pending)) begin
                    if (pending) begin
                        tick_overrun <= 1'b1;
                    end else begin
                        pending <= 1'b1;
                    end
                end

                case (state)
                    IDLE: begin
                        if (tick || pending) begin
                            state   <= SEC_OP;
                            pla     <= 3'b001;
                            s0      <= OP_INC;
                            busy    <= 1'b1;
                            pending <= 1'b0;
                        end else if (set_inc && (set_field != 2'd3)) begin
                            state <= SET_OP;
                            busy  <= 1'b1;
                            case (set_field)
                                2'd0: begin
                                    pla <= 3'b001;
                                    s0  <= OP_INC;
                                end
                                2'd1: begin
                                    pla <= 3'b010;
                                    s1  <= OP_INC;
                                end
                                default: begin
                                    pla <= 3'b100;
                                    s2  <= OP_INC;
                                end
                            endcase
                        end else begin
                            state <= IDLE;
                        end
                    end

                    SEC_OP: begin
                        state    <= SEC_WAIT;
                        wait_cnt <= WAIT_LOAD;
                        busy     <= 1'b1;
                    end

                    SEC_WAIT: begin
                        if (wait_cnt != 3'd0) begin
                            wait_cnt <= wait_cnt - 3'd1;
                            busy     <= 1'b1;
                        end else if (wrap_in) begin
                            state <= MIN_OP;
                            pla   <= 3'b010;
                            s1    <= OP_INC;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end

                    MIN_OP: begin
                        state    <= MIN_WAIT;
                        wait_cnt <= WAIT_LOAD;
                        busy     <= 1'b1;
                    end

                    MIN_WAIT: begin
                        if (wait_cnt != 3'd0) begin
                            wait_cnt <= wait_cnt - 3'd1;
                            busy     <= 1'b1;
                        end else if (wrap_in) begin
                            state <= HOUR_OP;
                            pla   <= 3'b100;
                            s2    <= OP_INC;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end

                    HOUR_OP: begin
                        state    <= HOUR_WAIT;
                        wait_cnt <= WAIT_LOAD;
                        busy     <= 1'b1;
                    end

                    HOUR_WAIT: begin
                        if (wait_cnt != 3'd0) begin
                            wait_cnt <= wait_cnt - 3'd1;
                            busy     <= 1'b1;
                        end else begin
                            // Hours is the end of the chain; an hour wrap
                            // only matters to the calendar downstream.
                            state <= IDLE;
`ifdef DAY_TICK_OUT_EN
                            day_tick <= wrap_in;
`endif
                        end
                    end

                    // Single-cycle ops; SET_OP never waits for or uses wrap_in.
                    CLR_OP:  state <= IDLE;
                    SET_OP:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
